mmio_uart_bridge: RTL and testbench
===================================

// Module: mmio_uart_bridge
// PURPOSE
//  Byte-stream initiator for the FPro MMIO bus; the master end of what the slot controller responds to.
//  Parses host commands from a UART rx byte stream and issues single FPro read/write transactions.
//  Returns ACK, NAK or read data on a tx byte stream.
//  Sits between a UART core's byte FIFOs and the MMIO bus, for board bring-up without the CPU.
// PARAMETERS
//  TIMEOUT_CYC  100_000  idle cycles allowed between bytes of one command before abort
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  rx_data       in   8   command byte from UART rx FIFO
//  rx_valid      in   1   rx_data valid
//  rx_ready      out  1   byte consumed when rx_valid & rx_ready
//  tx_data       out  8   response byte to UART tx FIFO
//  tx_valid      out  1   tx_data valid; held with tx_data stable until tx_ready
//  tx_ready      in   1   sink accepts byte this cycle
//  mmio_cs       out  1   bus chip select
//  mmio_wr       out  1   write strobe
//  mmio_rd       out  1   read strobe
//  mmio_addr     out  21  word address
//  mmio_wr_data  out  32  write data
//  mmio_rd_data  in   32  read data, combinational in the strobe cycle
//  busy          out  1   high in any state other than IDLE
//  err           out  1   sticky; set on any NAK; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; byte counter, timeout counter and shift registers cleared; any in-flight command dropped.
//  Opcodes: 0x57 'W' = write, then A2 A1 A0 D3 D2 D1 D0; 0x52 'R' = read, then A2 A1 A0. All fields MSB first.
//  Address: addr24 = {A2,A1,A0}. addr24[23:21] != 0 -> NAK, no bus cycle.
//  States: IDLE -> ADDR (3 bytes) -> [DATA (4 bytes, W only)] -> [CKSUM] -> BUS -> RESP -> IDLE. Any error -> NAK -> IDLE.
//  rx_ready: 1 only in IDLE, ADDR, DATA and CKSUM.
//  IDLE, unknown opcode: byte consumed -> NAK (0x15).
//  BUS: exactly one cycle with mmio_cs=1, and either mmio_wr=1 or mmio_rd=1.
//  mmio_addr and mmio_wr_data are stable in the BUS cycle. Read data is registered at the clock edge that ends it.
//  Write response: 0x06, sent one byte.
//  Read response: 4 bytes, MSB first, one per tx handshake.
//  tx_valid deasserts the cycle after the last byte's handshake.
//  Timeout: counter clears on every consumed byte. Runs in ADDR, DATA and CKSUM only.
//  When count == TIMEOUT_CYC-1 -> NAK, partial command discarded.
//  A byte arriving in the same cycle as expiry is consumed, and the timeout is not taken.
//  NAK state: one byte 0x15, then IDLE. err is set on entry.
//  No bus strobe is ever issued for a NAKed command. Latency from last command byte consumed to BUS cycle: 1 cycle.
// CONFIGURATION
//  MMIO_UART_BRIDGE_CKSUM_EN defined:
//   - an extra byte follows each command: XOR of the opcode and every preceding byte.
//   - mismatch -> NAK, no bus cycle.
//   - CKSUM is subject to the timeout.
//  Undefined: no CKSUM state; the bus cycle follows the last address or data byte.
// STRUCTURE
//  mmio_uart_bridge_pkg holds:
//   - opcode constants OP_WR=8'h57, OP_RD=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15;
//   - state_t enum (IDLE, ADDR, DATA, CKSUM, BUS, RESP, NAK);
//   - ADDR_W=21 and DATA_W=32.
//  Sub-module mmio_uart_bridge_ser: loads 1-4 bytes plus a count, drives tx_valid/tx_data, pulses done.
//  The top-level FSM keeps the rx parse, the timeout counter and the bus strobe.
// TESTING
//  1 Write: 57 00 00 10 DE AD BE EF -> one cycle with cs=wr=1, addr=0x10, wr_data=0xDEADBEEF; tx 06.
//  2 Read: 52 00 00 10, with responder returning 0x12345678 -> one cycle with cs=rd=1; tx 12 34 56 78. Hold tx_ready low 5 cycles mid-byte: data stable, no loss.
//  3 Bad opcode 0x41 -> tx 15, err=1, no strobe. Next, a valid read succeeds.
//  4 Address 52 E0 00 00 -> tx 15, no strobe.
//  5 Timeout (TIMEOUT_CYC=16): send 57 00 then stall 16 cycles -> tx 15, state IDLE.
//  6 Timeout boundary: stall 15 cycles then send a byte -> command continues.
//  7 Reset mid-read response, after byte 2 -> tx_valid=0 next cycle; busy=0, err=0; a new command works.
//  8 With MMIO_UART_BRIDGE_CKSUM_EN: 52 00 00 10 42 -> read OK. 52 00 00 10 43 -> tx 15, no strobe.

Source files
------------

// File: rtl/mmio_uart_bridge_pkg.sv
// Shared constants and types for the UART-to-MMIO bridge.
package mmio_uart_bridge_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        CKSUM,
        BUS,
        RESP,
        NAK
    } state_t;

endpackage

// File: rtl/mmio_uart_bridge_ser.sv
// Response serializer: loads 1-4 bytes (MSB first) and streams them out over a
// valid/ready byte interface. Pulses done the cycle after the last handshake.
module mmio_uart_bridge_ser
    import mmio_uart_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    input  logic [2:0]        load_cnt,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              done
);

    logic [DATA_W-1:0] word_q;
    logic [2:0]        left_q;

    // Byte shifter: present the top byte, advance on each accepted handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= '0;
            left_q   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                word_q   <= load_word << 8;
                left_q   <= load_cnt;
                tx_data  <= load_word[DATA_W-1 -: 8];
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                if (left_q == 3'd1) begin
                    left_q   <= '0;
                    tx_valid <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    tx_data <= word_q[DATA_W-1 -: 8];
                    word_q  <= word_q << 8;
                    left_q  <= left_q - 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mmio_uart_bridge.sv
// UART byte-stream to FPro MMIO bus initiator. Parses 'W'/'R' commands from the
// rx byte stream, issues one bus cycle per command and answers with ACK, NAK or
// read data. Define MMIO_UART_BRIDGE_CKSUM_EN to require a trailing XOR checksum
// byte on every command.
module mmio_uart_bridge
    import mmio_uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data,
    output logic              busy,
    output logic              err
);

`ifdef MMIO_UART_BRIDGE_CKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    localparam int unsigned TOUT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TOUT_W-1:0] TOUT_MAX = TOUT_W'(TIMEOUT_CYC - 1);

    state_t            state_q;
    logic              is_wr_q;
    logic [1:0]        byte_cnt_q;
    logic [TOUT_W-1:0] tout_q;
    logic [ADDR_W-1:0] addr_q;
    logic              addr_bad_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        cksum_q;

    logic              rx_fire;
    logic              cmd_last;
    logic              cmd_bad;
    logic              ser_load;
    logic [DATA_W-1:0] ser_word;
    logic [2:0]        ser_cnt;
    logic              ser_done;

    // Gated by reset so no byte is swallowed while the bridge is held in reset.
    assign rx_ready = !reset &&
                      (state_q == IDLE || state_q == ADDR || state_q == DATA || state_q == CKSUM);
    assign rx_fire  = rx_valid && rx_ready;
    assign busy     = (state_q != IDLE);

    assign mmio_addr    = addr_q;
    assign mmio_wr_data = wdata_q;

    // Final byte of the command body (or the checksum byte itself).
    assign cmd_last = (state_q == ADDR && byte_cnt_q == 2'd2) ||
                      (state_q == DATA && byte_cnt_q == 2'd3) ||
                      (state_q == CKSUM);
    assign cmd_bad  = addr_bad_q || (state_q == CKSUM && rx_data != cksum_q);

    // Serializer load: captures read data at the edge that ends the BUS cycle.
    always_comb begin
        ser_load = 1'b0;
        ser_word = '0;
        ser_cnt  = 3'd1;
        if (state_q == BUS) begin
            ser_load = 1'b1;
            if (is_wr_q) begin
                ser_word = {RSP_ACK, 24'h0};
            end else begin
                ser_word = mmio_rd_data;
                ser_cnt  = 3'd4;
            end
        end else if (state_q == NAK) begin
            ser_load = 1'b1;
            ser_word = {RSP_NAK, 24'h0};
        end
    end

    // Command FSM: rx parse, inter-byte timeout, single-cycle bus strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            is_wr_q    <= 1'b0;
            byte_cnt_q <= '0;
            tout_q     <= '0;
            addr_q     <= '0;
            addr_bad_q <= 1'b0;
            wdata_q    <= '0;
            cksum_q    <= '0;
            mmio_cs    <= 1'b0;
            mmio_wr    <= 1'b0;
            mmio_rd    <= 1'b0;
            err        <= 1'b0;
        end else begin
            mmio_cs <= 1'b0;
            mmio_wr <= 1'b0;
            mmio_rd <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_fire) begin
                        byte_cnt_q <= '0;
                        tout_q     <= '0;
                        addr_bad_q <= 1'b0;
                        cksum_q    <= rx_data;
                        if (rx_data == OP_WR || rx_data == OP_RD) begin
                            is_wr_q <= (rx_data == OP_WR);
                            state_q <= ADDR;
                        end else begin
                            state_q <= NAK;
                            err     <= 1'b1;
                        end
                    end
                end
                ADDR, DATA, CKSUM: begin
                    if (rx_fire) begin
                        tout_q     <= '0;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        cksum_q    <= cksum_q ^ rx_data;
                        if (state_q == ADDR) begin
                            addr_q <= {addr_q[ADDR_W-9:0], rx_data};
                            // addr24[23:21] live in the top bits of A2.
                            if (byte_cnt_q == 2'd0) addr_bad_q <= (rx_data[7:5] != 3'b000);
                        end
                        if (state_q == DATA) wdata_q <= {wdata_q[DATA_W-9:0], rx_data};

                        if (state_q == ADDR && byte_cnt_q == 2'd2 && is_wr_q) begin
                            byte_cnt_q <= '0;
                            state_q    <= DATA;
                        end else if (cmd_last) begin
                            byte_cnt_q <= '0;
                            if (CKSUM_EN && state_q != CKSUM) begin
                                state_q <= CKSUM;
                            end else if (cmd_bad) begin
                                state_q <= NAK;
                                err     <= 1'b1;
                            end else begin
                                state_q <= BUS;
                                mmio_cs <= 1'b1;
                                mmio_wr <= is_wr_q;
                                mmio_rd <= !is_wr_q;
                            end
                        end
                    end else if (tout_q == TOUT_MAX) begin
                        state_q <= NAK;
                        err     <= 1'b1;
                    end else begin
                        tout_q <= tout_q + TOUT_W'(1);
                    end
                end
                BUS:     state_q <= RESP;
                NAK:     state_q <= RESP;  // serializer loads 0x15 in this cycle
                RESP:    if (ser_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    mmio_uart_bridge_ser u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_word (ser_word),
        .load_cnt  (ser_cnt),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed bench for mmio_uart_bridge (TIMEOUT_CYC = 16). Commands carry a
// trailing checksum automatically when MMIO_UART_BRIDGE_CKSUM_EN is defined.
module tb_mmio_uart_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mmio_cs;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    mmio_uart_bridge #(.TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .mmio_cs      (mmio_cs),
        .mmio_wr      (mmio_wr),
        .mmio_rd      (mmio_rd),
        .mmio_addr    (mmio_addr),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_data (mmio_rd_data),
        .busy         (busy),
        .err          (err)
    );

    // Bus responder: read data only in the strobe cycle.
    logic [31:0] resp_word;
    assign mmio_rd_data = mmio_rd ? resp_word : 32'h0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_rx_cyc;
    int          strobes;
    int          last_cs_cyc;
    logic        last_wr;
    logic        last_rd;
    logic [20:0] last_addr;
    logic [31:0] last_wdata;
    logic [7:0]  ck_acc;
    logic [7:0]  txq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors sample on the falling edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (mmio_cs) begin
            strobes++;
            last_cs_cyc = cyc;
            last_wr     = mmio_wr;
            last_rd     = mmio_rd;
            last_addr   = mmio_addr;
            last_wdata  = mmio_wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (rx_ready) ok = 1'b1;
            tick();
        end
        rx_valid    = 1'b0;
        last_rx_cyc = cyc;
        ck_acc      = ck_acc ^ b;
        if (!ok) check("rx_accept", 32'd0, 32'd1);
    endtask

    task automatic send_ck();
`ifdef MMIO_UART_BRIDGE_CKSUM_EN
        send(ck_acc);
`endif
    endtask

    task automatic start_cmd();
        txq.delete();
        strobes = 0;
        ck_acc  = 8'h00;
    endtask

    task automatic cmd_rd(input logic [23:0] a);
        start_cmd();
        send(8'h52);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
        send_ck();
    endtask

    task automatic cmd_wr(input logic [23:0] a, input logic [31:0] d);
        start_cmd();
        send(8'h57);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
        send(d[31:24]);
        send(d[23:16]);
        send(d[15:8]);
        send(d[7:0]);
        send_ck();
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 300 && txq.size() < n; i++) tick();
        if (txq.size() < n) check("tx_wait", txq.size(), n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) tick();
        check("idle", busy, 1'b0);
    endtask

    task automatic check_rd(input string tag, input logic [31:0] w);
        check({tag, "_len"}, txq.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("%s_b%0d", tag, i), txq[i], w[31-8*i -: 8]);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b1;
        resp_word = 32'h0;
        ck_acc    = 8'h00;
        strobes   = 0;
        repeat (3) tick();
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cs", mmio_cs, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b0);
        reset = 1'b0;
        tick();
        check("idle_rx_ready", rx_ready, 1'b1);

        // 1: write
        cmd_wr(24'h000010, 32'hDEADBEEF);
        wait_tx(1);
        wait_idle();
        check("wr_strobes", strobes, 1);
        check("wr_latency", last_cs_cyc, last_rx_cyc);
        check("wr_wr", last_wr, 1'b1);
        check("wr_rd", last_rd, 1'b0);
        check("wr_addr", last_addr, 21'h10);
        check("wr_data", last_wdata, 32'hDEADBEEF);
        check("wr_len", txq.size(), 1);
        check("wr_ack", txq[0], 8'h06);
        check("wr_err", err, 1'b0);

        // 2: read with tx back-pressure mid-response
        resp_word = 32'h12345678;
        cmd_rd(24'h000010);
        wait_tx(1);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", tx_valid, 1'b1);
            check("hold_data", tx_data, 8'h34);
        end
        check("hold_len", txq.size(), 1);
        tx_ready = 1'b1;
        wait_tx(4);
        check("rd_valid_drop", tx_valid, 1'b0);
        wait_idle();
        check("rd_strobes", strobes, 1);
        check("rd_latency", last_cs_cyc, last_rx_cyc);
        check("rd_rd", last_rd, 1'b1);
        check("rd_wr", last_wr, 1'b0);
        check("rd_addr", last_addr, 21'h10);
        check_rd("rd", 32'h12345678);

        // 3: unknown opcode, then a read still works
        start_cmd();
        send(8'h41);
        wait_tx(1);
        wait_idle();
        check("badop_nak", txq[0], 8'h15);
        check("badop_len", txq.size(), 1);
        check("badop_err", err, 1'b1);
        check("badop_strobes", strobes, 0);
        resp_word = 32'hA5C30F01;
        cmd_rd(24'h1FFFFF);
        wait_tx(4);
        wait_idle();
        check("rd2_strobes", strobes, 1);
        check("rd2_addr", last_addr, 21'h1FFFFF);
        check_rd("rd2", 32'hA5C30F01);

        // 4: out-of-range address
        cmd_rd(24'hE00000);
        wait_tx(1);
        wait_idle();
        check("addr_nak", txq[0], 8'h15);
        check("addr_len", txq.size(), 1);
        check("addr_strobes", strobes, 0);

        // 5: timeout after 16 idle cycles
        start_cmd();
        send(8'h57);
        send(8'h00);
        repeat (15) tick();
        check("tout15_rx_ready", rx_ready, 1'b1);
        check("tout15_tx_valid", tx_valid, 1'b0);
        tick();
        check("tout16_rx_ready", rx_ready, 1'b0);
        wait_tx(1);
        wait_idle();
        check("tout_nak", txq[0], 8'h15);
        check("tout_len", txq.size(), 1);
        check("tout_strobes", strobes, 0);

        // 6: byte arriving on the expiry cycle keeps the command alive
        resp_word = 32'h0BADF00D;
        start_cmd();
        send(8'h52);
        send(8'h00);
        repeat (15) tick();
        send(8'h00);
        send(8'h10);
        send_ck();
        wait_tx(4);
        wait_idle();
        check("edge_strobes", strobes, 1);
        check_rd("edge", 32'h0BADF00D);

        // 7: reset during read response
        resp_word = 32'hCAFEF00D;
        cmd_rd(24'h000010);
        wait_tx(2);
        reset = 1'b1;
        tick();
        check("rst7_tx_valid", tx_valid, 1'b0);
        check("rst7_busy", busy, 1'b0);
        check("rst7_err", err, 1'b0);
        reset = 1'b0;
        tick();
        cmd_wr(24'h000123, 32'h00000005);
        wait_tx(1);
        wait_idle();
        check("rst7_wr_strobes", strobes, 1);
        check("rst7_wr_addr", last_addr, 21'h123);
        check("rst7_wr_data", last_wdata, 32'h5);
        check("rst7_ack", txq[0], 8'h06);

`ifdef MMIO_UART_BRIDGE_CKSUM_EN
        // 8: explicit checksum good / bad
        resp_word = 32'h87654321;
        start_cmd();
        send(8'h52); send(8'h00); send(8'h00); send(8'h10); send(8'h42);
        wait_tx(4);
        wait_idle();
        check("ck_ok_strobes", strobes, 1);
        check_rd("ck_ok", 32'h87654321);
        start_cmd();
        send(8'h52); send(8'h00); send(8'h00); send(8'h10); send(8'h43);
        wait_tx(1);
        wait_idle();
        check("ck_bad_nak", txq[0], 8'h15);
        check("ck_bad_len", txq.size(), 1);
        check("ck_bad_strobes", strobes, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
